ghost_motion_controller: RTL

- Upstream stage of the display controller. Owns grid positions and headings of NUM_GHOSTS ghosts.
- Once per frame, after the display pass ends, it sweeps the ghosts in order. For each ghost it queries the maze map for the next cell, then moves the ghost or turns it.
- It publishes pixel coordinates as ghostN_vga_x/y for the display controller. All ghosts update together, so the display never draws a half-updated set.

---
 rtl/ghost_pkg.sv | 29 ++
 rtl/ghost_motion_controller_lfsr8.sv | 19 +
 rtl/ghost_motion_controller.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ghost_pkg.sv
// Shared types and defaults for the ghost motion controller: headings, sweep FSM
// encoding, maze geometry defaults and the direction-LFSR step.
package ghost_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CALC   = 3'd1,
    ST_QUERY  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DECIDE = 3'd4,
    ST_COMMIT = 3'd5
  } state_t;

  localparam int GRID_DEFAULT    = 21;
  localparam int CELL_PX_DEFAULT = 5;

  // Fibonacci form, taps 8,6,5,4 (bit 8 is the MSB).
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/ghost_motion_controller_lfsr8.sv
// Free-running 8-bit LFSR supplying pseudo-random headings to blocked ghosts.
module lfsr8
  import ghost_pkg::*;
(
  input  logic       clock_50,
  input  logic       reset,
  input  logic [7:0] seed,
  output logic [7:0] state
);

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state <= seed;
    end else begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/ghost_motion_controller.sv
// Per-frame ghost mover: after each display pass, sweeps the ghosts, asks the maze
// map about each one's next cell, then publishes all pixel positions at once.
module ghost_motion_controller
  import ghost_pkg::*;
#(
  parameter int                      NUM_GHOSTS    = 7,
  parameter int                      GRID          = GRID_DEFAULT,
  parameter int                      CELL_PX       = CELL_PX_DEFAULT,
  parameter logic [5*NUM_GHOSTS-1:0] INIT_X        = '0,
  parameter logic [5*NUM_GHOSTS-1:0] INIT_Y        = '0,
  parameter logic [7:0]              LFSR_SEED     = 8'hA5,
  parameter int                      QUERY_TIMEOUT = 15
) (
  input  logic                    clock_50,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    frame_active,
  output logic                    cell_req,
  output logic [4:0]              cell_x,
  output logic [4:0]              cell_y,
  input  logic                    cell_valid,
  input  logic                    cell_is_wall,
  output logic [8*NUM_GHOSTS-1:0] ghost_vga_x,
  output logic [8*NUM_GHOSTS-1:0] ghost_vga_y,
  output logic                    busy
);

  localparam int                 TMR_W      = $clog2(QUERY_TIMEOUT + 1);
  localparam logic [TMR_W-1:0]   TIMER_LAST = TMR_W'(QUERY_TIMEOUT - 1);
  localparam logic [2:0]         IDX_LAST   = 3'(NUM_GHOSTS - 1);
  localparam logic signed [5:0]  MAX_CELL   = 6'(GRID - 1);

  state_t             state;
  logic [2:0]         idx;
  logic [4:0]         pos_x   [NUM_GHOSTS];
  logic [4:0]         pos_y   [NUM_GHOSTS];
  dir_t               heading [NUM_GHOSTS];
  logic [4:0]         cand_x;
  logic [4:0]         cand_y;
  logic               blocked;
  logic [TMR_W-1:0]   timer;
  logic               frame_active_prev;
  logic               frame_tick;
  logic [7:0]         lfsr_q;
  logic               unused_lfsr;
  logic signed [5:0]  step_x;
  logic signed [5:0]  step_y;

  function automatic logic [7:0] to_px(input logic [4:0] c);
    return 8'(int'(c) * CELL_PX);
  endfunction

  function automatic logic in_grid(input logic signed [5:0] v);
    return (v >= 6'sd0) && (v <= MAX_CELL);
  endfunction

  // A random pick equal to the current heading is nudged clockwise so a blocked
  // ghost always faces somewhere new.
  function automatic dir_t turn_dir(input dir_t cur, input logic [1:0] r);
    dir_t n;
    n = dir_t'(r);
    if (n == cur) n = dir_t'(cur + 2'd1);
    return n;
  endfunction

  lfsr8 u_lfsr (
    .clock_50 (clock_50),
    .reset    (reset),
    .seed     (LFSR_SEED),
    .state    (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[7:2];
  assign frame_tick  = frame_active_prev & ~frame_active;

  // Candidate cell in 6-bit signed so a step left/up from 0 shows up as -1.
  always_comb begin
    step_x = $signed({1'b0, pos_x[idx]});
    step_y = $signed({1'b0, pos_y[idx]});
    case (heading[idx])
      DIR_UP:    step_y = step_y - 6'sd1;
      DIR_RIGHT: step_x = step_x + 6'sd1;
      DIR_DOWN:  step_y = step_y + 6'sd1;
      default:   step_x = step_x - 6'sd1;
    endcase
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state             <= ST_IDLE;
      idx               <= '0;
      cand_x            <= '0;
      cand_y            <= '0;
      blocked           <= 1'b0;
      timer             <= '0;
      frame_active_prev <= 1'b0;
      cell_req          <= 1'b0;
      cell_x            <= '0;
      cell_y            <= '0;
      busy              <= 1'b0;
      for (int i = 0; i < NUM_GHOSTS; i++) begin
        pos_x[i]              <= INIT_X[5*i +: 5];
        pos_y[i]              <= INIT_Y[5*i +: 5];
        heading[i]            <= DIR_RIGHT;
        ghost_vga_x[8*i +: 8] <= to_px(INIT_X[5*i +: 5]);
        ghost_vga_y[8*i +: 8] <= to_px(INIT_Y[5*i +: 5]);
      end
    end else begin
      frame_active_prev <= frame_active;
      cell_req          <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (frame_tick && en) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= ST_CALC;
          end
        end

        ST_CALC: begin
          cand_x <= step_x[4:0];
          cand_y <= step_y[4:0];
          if (in_grid(step_x) && in_grid(step_y)) begin
            state <= ST_QUERY;
          end else begin
            blocked <= 1'b1;
            state   <= ST_DECIDE;
          end
        end

        ST_QUERY: begin
          cell_x   <= cand_x;
          cell_y   <= cand_y;
          cell_req <= 1'b1;
          timer    <= '0;
          state    <= ST_WAIT;
        end

        // A response in the final timeout cycle still wins over the timeout.
        ST_WAIT: begin
          if (cell_valid) begin
            blocked <= cell_is_wall;
            state   <= ST_DECIDE;
          end else if (timer == TIMER_LAST) begin
            blocked <= 1'b1;
            state   <= ST_DECIDE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_DECIDE: begin
          if (blocked) begin
            heading[idx] <= turn_dir(heading[idx], lfsr_q[1:0]);
          end else begin
            pos_x[idx] <= cand_x;
            pos_y[idx] <= cand_y;
          end
          blocked <= 1'b0;
          if (idx == IDX_LAST) begin
            state <= ST_COMMIT;
          end else begin
            idx   <= idx + 3'd1;
            state <= ST_CALC;
          end
        end

        ST_COMMIT: begin
          for (int i = 0; i < NUM_GHOSTS; i++) begin
            ghost_vga_x[8*i +: 8] <= to_px(pos_x[i]);
            ghost_vga_y[8*i +: 8] <= to_px(pos_y[i]);
          end
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
